// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller.
// Latches hall and cabin calls, serves them with a collective (SCAN) sweep,
// holds the door open while the car is overloaded and tracks occupancy.
// All travel and door timing advances only on the slow tick strobe.
module elevator_ctrl_n #(
   parameter int FLOORS       = 4,
   parameter int FW           = 2,
   parameter int TRAVEL_TICKS = 2,
   parameter int DOOR_TICKS   = 3,
   parameter int MAX_PEOPLE   = 6,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic [FLOORS-1:0] call_ext,
   input  logic [FLOORS-1:0] call_int,
   input  logic              people_up,
   input  logic              people_down,
   output logic [FW-1:0]     floor,
   output logic [FLOORS-1:0] pending,
   output logic              door_open,
   output logic              moving,
   output logic              dir_up,
   output logic [CNT_W-1:0]  people,
   output logic              alarm
);

   localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
   localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
   localparam logic [TW-1:0]    TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
   localparam logic [DW-1:0]    DOOR_LAST   = DW'(DOOR_TICKS - 1);
   localparam logic [CNT_W-1:0] PEOPLE_SAT  = '1;
   localparam logic [CNT_W-1:0] PEOPLE_MAX  = CNT_W'(MAX_PEOPLE);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t            state;
   logic [TW-1:0]     travel_cnt;
   logic [DW-1:0]     door_cnt;
   logic              arrived;
   logic [FLOORS-1:0] pend_in;
   logic [FLOORS-1:0] floor_oh;
   logic              cur_call;
   logic              calls_up;
   logic              calls_dn;
   logic [FW-1:0]     next_floor;

   // Saturating occupancy update; simultaneous enter/leave cancels out.
   function automatic logic [CNT_W-1:0] occ_next(input logic [CNT_W-1:0] cnt,
                                                 input logic up,
                                                 input logic dn);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (up && !dn && (cnt != PEOPLE_SAT))
         res = cnt + CNT_W'(1);
      else if (dn && !up && (cnt != '0))
         res = cnt - CNT_W'(1);
      return res;
   endfunction

   // Call merge, current-floor mask and which side of the car has calls.
   always_comb begin
      pend_in    = pending | call_ext | call_int;
      floor_oh   = FLOORS'(1) << floor;
      cur_call   = |(pending & floor_oh);
      next_floor = dir_up ? (floor + FW'(1)) : (floor - FW'(1));
      calls_up   = 1'b0;
      calls_dn   = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (pending[i] && (i > int'(floor))) calls_up = 1'b1;
         if (pending[i] && (i < int'(floor))) calls_dn = 1'b1;
      end
   end

   // Car sequencer: call register, SCAN direction choice, travel and door timers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         floor      <= '0;
         pending    <= '0;
         door_open  <= 1'b0;
         moving     <= 1'b0;
         dir_up     <= 1'b1;
         travel_cnt <= '0;
         door_cnt   <= '0;
         arrived    <= 1'b0;
      end else begin
         pending <= pend_in;
         case (state)
            IDLE: begin
               if (cur_call) begin
                  state     <= DOOR;
                  door_open <= 1'b1;
                  door_cnt  <= '0;
                  pending   <= pend_in & ~floor_oh;
               end else if (calls_up || calls_dn) begin
                  state      <= MOVE;
                  moving     <= 1'b1;
                  travel_cnt <= '0;
                  arrived    <= 1'b0;
                  // Reverse only when nothing remains in the current sweep direction.
                  if (dir_up ? !calls_up : !calls_dn) dir_up <= ~dir_up;
               end
            end
            MOVE: begin
               arrived <= 1'b0;
               // The stop decision is taken the clk after the floor step.
               if (arrived && cur_call) begin
                  state      <= DOOR;
                  moving     <= 1'b0;
                  door_open  <= 1'b1;
                  door_cnt   <= '0;
                  travel_cnt <= '0;
                  pending    <= pend_in & ~floor_oh;
               end else if (tick) begin
                  if (travel_cnt == TRAVEL_LAST) begin
                     floor      <= next_floor;
                     travel_cnt <= '0;
                     arrived    <= 1'b1;
                  end else begin
                     travel_cnt <= travel_cnt + TW'(1);
                  end
               end
            end
            DOOR: begin
               // Calls at the open floor are absorbed rather than queued.
               pending <= pend_in & ~floor_oh;
               if (alarm) begin
                  door_cnt <= '0;
               end else if (tick) begin
                  if (door_cnt == DOOR_LAST) begin
                     state     <= IDLE;
                     door_open <= 1'b0;
                     door_cnt  <= '0;
                  end else begin
                     door_cnt <= door_cnt + DW'(1);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               door_open <= 1'b0;
               moving    <= 1'b0;
            end
         endcase
      end
   end

   // Occupancy counter (door must be open) and registered overload alarm.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         people <= '0;
         alarm  <= 1'b0;
      end else begin
         alarm <= (people > PEOPLE_MAX);
         if (door_open) people <= occ_next(people, people_up, people_down);
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n with default parameters, tick every 8 clk.
module tb_elevator_ctrl_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [3:0] call_ext;
   logic [3:0] call_int;
   logic       people_up;
   logic       people_down;
   logic [1:0] floor;
   logic [3:0] pending;
   logic       door_open;
   logic       moving;
   logic       dir_up;
   logic [2:0] people;
   logic       alarm;

   int checks = 0;
   int passes = 0;
   int tph    = 0;

   typedef struct {
      logic up;
      logic dn;
      int   ppl;
      logic alm;
   } occ_row_t;

   occ_row_t rows [13];

   elevator_ctrl_n #(
      .FLOORS(4), .FW(2), .TRAVEL_TICKS(2), .DOOR_TICKS(3), .MAX_PEOPLE(6), .CNT_W(3)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .call_ext(call_ext), .call_int(call_int),
      .people_up(people_up), .people_down(people_down),
      .floor(floor), .pending(pending), .door_open(door_open),
      .moving(moving), .dir_up(dir_up), .people(people), .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One clock: tick is high on one edge out of every eight.
   task automatic cycle();
      tick = (tph == 0);
      tph  = (tph == 7) ? 0 : tph + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick = 1'b0;
      call_ext = '0; call_int = '0; people_up = 1'b0; people_down = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      tph = 1;
   endtask

   task automatic wait_door(input logic level, input int budget, input string name);
      for (int c = 0; c < budget; c++) begin
         if (door_open == level) break;
         cycle();
      end
      chk(name, door_open, level);
   endtask

   // Count ticks seen while the door is open with no alarm, until it closes.
   task automatic count_door_ticks(input int budget, output int nt);
      logic pd, pa, closed;
      nt = 0; closed = 1'b0;
      for (int c = 0; c < budget; c++) begin
         pd = door_open; pa = alarm;
         cycle();
         if (tick && pd && !pa) nt++;
         if (!door_open) begin closed = 1'b1; break; end
      end
      if (!closed) nt = -1;
   endtask

   task automatic open_door_at_0();
      call_int = 4'b0001; cycle(); call_int = '0;
      wait_door(1'b1, 20, "door_open_at_0");
   endtask

   initial begin
      int nt, bad, ok;
      logic pm, pd;
      logic [1:0] pf;
      int stops [$];
      bit injected;

      rows[0]  = '{1'b0, 1'b1, 0, 1'b0};
      rows[1]  = '{1'b1, 1'b0, 1, 1'b0};
      rows[2]  = '{1'b1, 1'b1, 1, 1'b0};
      rows[3]  = '{1'b1, 1'b0, 2, 1'b0};
      rows[4]  = '{1'b1, 1'b0, 3, 1'b0};
      rows[5]  = '{1'b1, 1'b0, 4, 1'b0};
      rows[6]  = '{1'b1, 1'b0, 5, 1'b0};
      rows[7]  = '{1'b1, 1'b0, 6, 1'b0};
      rows[8]  = '{1'b1, 1'b0, 7, 1'b0};
      rows[9]  = '{1'b1, 1'b0, 7, 1'b1};
      rows[10] = '{1'b1, 1'b1, 7, 1'b1};
      rows[11] = '{1'b0, 1'b1, 6, 1'b1};
      rows[12] = '{1'b0, 1'b1, 5, 1'b0};

      // Reset state, then 100 clk with no calls.
      reset = 1'b1; tick = 1'b0;
      call_ext = '0; call_int = '0; people_up = 1'b0; people_down = 1'b0;
      #12;
      chk("rst_floor", floor, 0);
      chk("rst_pending", pending, 0);
      chk("rst_door", door_open, 0);
      chk("rst_moving", moving, 0);
      chk("rst_dir_up", dir_up, 1);
      chk("rst_people", people, 0);
      chk("rst_alarm", alarm, 0);
      do_reset();
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         cycle();
         if (floor != 0 || door_open || moving) bad++;
      end
      chk("idle_100clk", bad, 0);

      // Call at the current floor.
      call_int = 4'b0001; cycle(); call_int = '0;
      chk("c0_pending_set", pending, 1);
      chk("c0_door_not_yet", door_open, 0);
      cycle();
      chk("c0_door_open", door_open, 1);
      chk("c0_pending_clr", pending, 0);
      count_door_ticks(200, nt);
      chk("c0_door_ticks", nt, 3);
      cycle();
      chk("c0_idle_door", door_open, 0);
      chk("c0_idle_moving", moving, 0);
      chk("c0_idle_pending", pending, 0);

      // Remote call: 0 -> 3, two ticks per floor.
      do_reset();
      call_ext = 4'b1000; cycle(); call_ext = '0;
      chk("c3_pending_set", pending, 8);
      cycle();
      chk("c3_moving", moving, 1);
      chk("c3_dir_up", dir_up, 1);
      chk("c3_floor_start", floor, 0);
      nt = 0; ok = 0; bad = 0;
      for (int c = 0; c < 300; c++) begin
         pm = moving; pf = floor;
         cycle();
         if (tick && pm) nt++;
         if (!dir_up || door_open) bad++;
         if (floor != pf) begin
            chk($sformatf("c3_ticks_to_f%0d", floor), nt, 2);
            chk($sformatf("c3_step_f%0d", floor), floor, pf + 1);
            nt = 0;
            if (floor == 3) begin ok = 1; break; end
         end
      end
      chk("c3_reached", ok, 1);
      chk("c3_no_reverse_no_door", bad, 0);
      chk("c3_arrive_door_closed", door_open, 0);
      cycle();
      chk("c3_arrive_door_open", door_open, 1);
      chk("c3_arrive_stopped", moving, 0);
      wait_door(1'b0, 200, "c3_door_closes");
      chk("c3_final_pending", pending, 0);
      chk("c3_final_floor", floor, 3);

      // Collective sweep: {1,3} pending, 2 added while leaving floor 1.
      do_reset();
      call_ext = 4'b1010; cycle(); call_ext = '0;
      injected = 0; bad = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!injected && stops.size() == 1 && moving && floor == 1) begin
            call_ext = 4'b0100; injected = 1;
         end
         pd = door_open;
         cycle();
         call_ext = '0;
         if (moving && !dir_up) bad++;
         if (door_open && !pd) stops.push_back(int'(floor));
         if (stops.size() == 3) break;
      end
      chk("sweep_stop_count", stops.size(), 3);
      chk("sweep_injected", injected, 1);
      for (int i = 0; i < 3; i++)
         chk($sformatf("sweep_stop%0d", i), (stops.size() > i) ? stops[i] : -1, i + 1);
      chk("sweep_no_reverse", bad, 0);
      wait_door(1'b0, 200, "sweep_door_closes");
      chk("sweep_pending_clear", pending, 0);

      // Occupancy table, applied on consecutive clk with the door open.
      do_reset();
      open_door_at_0();
      for (int i = 0; i < 13; i++) begin
         people_up = rows[i].up; people_down = rows[i].dn;
         cycle();
         people_up = 1'b0; people_down = 1'b0;
         chk($sformatf("occ%0d_people", i), people, rows[i].ppl);
         chk($sformatf("occ%0d_alarm", i), alarm, rows[i].alm);
         chk($sformatf("occ%0d_door", i), door_open, 1);
      end

      // Overload holds the door; it closes three ticks after the alarm clears.
      do_reset();
      open_door_at_0();
      for (int i = 0; i < 7; i++) begin
         people_up = 1'b1; cycle();
      end
      people_up = 1'b0;
      chk("ovl_people7", people, 7);
      cycle();
      chk("ovl_alarm_on", alarm, 1);
      bad = 0;
      for (int c = 0; c < 160; c++) begin
         cycle();
         if (!door_open || moving) bad++;
      end
      chk("ovl_door_held_20_ticks", bad, 0);
      people_down = 1'b1; cycle(); people_down = 1'b0;
      chk("ovl_people6", people, 6);
      cycle();
      chk("ovl_alarm_off", alarm, 0);
      chk("ovl_still_open", door_open, 1);
      count_door_ticks(200, nt);
      chk("ovl_close_ticks", nt, 3);

      // Pulses with the door closed are ignored.
      people_up = 1'b1; cycle(); people_up = 1'b0; cycle();
      chk("closed_up_ignored", people, 6);
      people_down = 1'b1; cycle(); people_down = 1'b0; cycle();
      chk("closed_down_ignored", people, 6);

      // Asynchronous reset in the middle of a move.
      call_ext = 4'b1000; cycle(); call_ext = '0;
      ok = 0;
      for (int c = 0; c < 200; c++) begin
         cycle();
         if (moving && floor == 1) begin ok = 1; break; end
      end
      chk("mid_move_reached_f1", ok, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_floor", floor, 0);
      chk("mid_rst_moving", moving, 0);
      chk("mid_rst_pending", pending, 0);
      chk("mid_rst_dir_up", dir_up, 1);
      chk("mid_rst_people", people, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      cycle(); cycle();
      chk("post_rst_idle", moving, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
